// File: rtl/jpu_mem_arbiter.sv
// Round-robin arbiter and sizer that shares one Wishbone B4 classic master between JPU fetch and load/store.
// Optional bus watchdog enabled by defining JPU_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
//
// state  | meaning
// IDLE   | no bus cycle; arbitrate pending requests
// IF_BUS | bus cycle in progress for the fetch port
// D_BUS  | bus cycle in progress for the data port
// RESP   | one-cycle ack/err pulse to the owning port
module jpu_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_se,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_BUS = 2'd1,
        D_BUS  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // memsize encoding; the unused code 2'b11 behaves as WORD
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("jpu_mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state;
    logic        last_if;
    logic [1:0]  size_q;
    logic        se_q;
    logic [1:0]  lane_q;

    logic        grant_d;
    logic        d_misaligned;
    logic        if_misaligned;
    logic [3:0]  d_sel;
    logic [31:0] d_wdat;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic        bus_done;
    logic        bus_err;

`ifdef JPU_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (({1'b0, tmo_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
`endif

    // data wins a tie unless it was the last port granted
    assign grant_d       = d_req & (~if_req | last_if);
    assign if_misaligned = |if_addr[1:0];

    always_comb begin
        d_misaligned = 1'b0;
        d_sel        = 4'b1111;
        d_wdat       = d_wdata;
        case (d_size)
            SIZE_BYTE: begin
                d_sel  = 4'b0001 << d_addr[1:0];
                d_wdat = {4{d_wdata[7:0]}};
            end
            SIZE_HALF: begin
                d_misaligned = d_addr[0];
                d_sel        = 4'b0011 << {d_addr[1], 1'b0};
                d_wdat       = {2{d_wdata[15:0]}};
            end
            default: d_misaligned = |d_addr[1:0];
        endcase
    end

    always_comb begin
        lane_data = wb_dat_i >> {lane_q, 3'b000};
        load_data = wb_dat_i;
        case (size_q)
            SIZE_BYTE: load_data = {{24{se_q & lane_data[7]}}, lane_data[7:0]};
            SIZE_HALF: load_data = {{16{se_q & lane_data[15]}}, lane_data[15:0]};
            default:   load_data = wb_dat_i;
        endcase
    end

    // an error always wins over a simultaneous ack
    always_comb begin
        bus_done = wb_ack_i | wb_err_i;
        bus_err  = wb_err_i;
`ifdef JPU_ARB_TIMEOUT_EN
        if (!bus_done && tmo_hit) begin
            bus_done = 1'b1;
            bus_err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_if  <= 1'b1;
            size_q   <= 2'd2;
            se_q     <= 1'b0;
            lane_q   <= 2'd0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            if_rdata <= '0;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            d_rdata  <= '0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
`ifdef JPU_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
`ifdef JPU_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (grant_d) begin
                        last_if <= 1'b0;
                        if (d_misaligned) begin
                            state <= RESP;
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end else begin
                            state    <= D_BUS;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= d_we;
                            wb_adr_o <= {d_addr[31:2], 2'b00};
                            wb_sel_o <= d_sel;
                            wb_dat_o <= d_wdat;
                            size_q   <= d_size;
                            se_q     <= d_se;
                            lane_q   <= d_addr[1:0];
                        end
                    end else if (if_req) begin
                        last_if <= 1'b1;
                        if (if_misaligned) begin
                            state  <= RESP;
                            if_ack <= 1'b1;
                            if_err <= 1'b1;
                        end else begin
                            state    <= IF_BUS;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_adr_o <= {if_addr[31:2], 2'b00};
                            wb_sel_o <= 4'b1111;
                        end
                    end
                end
                IF_BUS, D_BUS: begin
                    if (bus_done) begin
                        state    <= RESP;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (state == D_BUS) begin
                            d_ack <= 1'b1;
                            d_err <= bus_err;
                            if (!bus_err && !wb_we_o) d_rdata <= load_data;
                        end else begin
                            if_ack <= 1'b1;
                            if_err <= bus_err;
                            if (!bus_err) if_rdata <= wb_dat_i;
                        end
                    end
`ifdef JPU_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpu_mem_arbiter.sv
// Testbench for jpu_mem_arbiter: directed vector table, hand-written corner sequences and a randomized
// two-port run checked against a transaction-level reference model.
module tb_jpu_mem_arbiter;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack, if_err;
    logic        d_req, d_we, d_se;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack, d_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    int n_cmp  = 0;
    int n_fail = 0;

    jpu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_se(d_se), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- slave model ----------------
    logic        slave_silent = 1'b0;
    logic        err_force    = 1'b0;
    logic        rand_mode    = 1'b0;
    logic [31:0] slave_rdata  = '0;
    int          wait_cnt     = 0;
    logic        slave_ready, slave_err;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic addr_err(logic [31:0] a);
        return (int'(a[11:2]) % 7) == 3;
    endfunction

    assign slave_ready = wb_cyc_o && wb_stb_o && !slave_silent &&
                         (wait_cnt >= (rand_mode ? int'(wb_adr_o[5:4]) : 0));
    assign slave_err   = rand_mode ? addr_err(wb_adr_o) : err_force;
    assign wb_ack_i    = slave_ready && !slave_err;
    assign wb_err_i    = slave_ready && slave_err;
    assign wb_dat_i    = rand_mode ? mem_word(wb_adr_o) : slave_rdata;

    always @(posedge clk_i) wait_cnt <= wb_cyc_o ? wait_cnt + 1 : 0;

    // ---------------- bus monitor ----------------
    logic [31:0] lb_adr = '0, lb_dat = '0;
    logic [3:0]  lb_sel = '0;
    logic        lb_we  = 1'b0;
    logic [31:0] grant_q[$];

    always @(posedge clk_i) begin
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
            lb_adr <= wb_adr_o;
            lb_dat <= wb_dat_o;
            lb_sel <= wb_sel_o;
            lb_we  <= wb_we_o;
            grant_q.push_back(wb_adr_o);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_sel(logic [1:0] size, logic [31:0] a);
        int off = int'(a % 4);
        if (size == SZ_B) return 4'(1 << off);
        if (size == SZ_H) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdat(logic [1:0] size, logic [31:0] w);
        if (size == SZ_B) return (w & 32'hFF) * 32'h01010101;
        if (size == SZ_H) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] size, logic se, logic [31:0] a, logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        if (size == SZ_B) begin
            v = v & 32'hFF;
            if (se && v >= 128) v = v - 256;
        end else if (size == SZ_H) begin
            v = v & 32'hFFFF;
            if (se && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One data access; returns what was seen on the port and on the bus.
    task automatic do_data(input logic we, input logic [1:0] size, input logic se,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic got_err, output logic [31:0] got_rdata, output int lat,
                           output logic saw_cyc, output logic [3:0] bsel,
                           output logic [31:0] bdat, output logic bwe);
        got_err = 1'b0; got_rdata = '0; lat = 0; saw_cyc = 1'b0; bsel = '0; bdat = '0; bwe = 1'b0;
        @(negedge clk_i);
        d_we = we; d_size = size; d_se = se; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk_i); #1;
            if (wb_cyc_o && !saw_cyc) begin
                saw_cyc = 1'b1; bsel = wb_sel_o; bdat = wb_dat_o; bwe = wb_we_o;
            end
            if (d_ack) begin
                lat = c; got_err = d_err; got_rdata = d_rdata;
                break;
            end
        end
        d_req = 1'b0;
        @(posedge clk_i); #1;
        if (wb_cyc_o) saw_cyc = 1'b1;
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic got_err, output logic [31:0] got_rdata,
                            output int lat, output logic saw_cyc, output logic [3:0] bsel, output logic bwe);
        got_err = 1'b0; got_rdata = '0; lat = 0; saw_cyc = 1'b0; bsel = '0; bwe = 1'b0;
        @(negedge clk_i);
        if_addr = addr; if_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk_i); #1;
            if (wb_cyc_o && !saw_cyc) begin
                saw_cyc = 1'b1; bsel = wb_sel_o; bwe = wb_we_o;
            end
            if (if_ack) begin
                lat = c; got_err = if_err; got_rdata = if_rdata;
                break;
            end
        end
        if_req = 1'b0;
        @(posedge clk_i); #1;
        if (wb_cyc_o) saw_cyc = 1'b1;
    endtask

    // ---------------- randomized two-port run ----------------
    int d_others = 0, i_others = 0;

    task automatic rand_data(input int n);
        logic [1:0] size; logic se, we; logic [31:0] addr, wdata, wa; logic got, exp_err;
        for (int t = 0; t < n; t++) begin
            @(negedge clk_i);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            size  = 2'($urandom_range(0, 2));
            se    = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            wa    = ($urandom & 32'h0000_3FFC) | 32'h1000_0000;
            addr  = wa;
            if (size == SZ_B) addr = wa + 32'($urandom_range(0, 3));
            if (size == SZ_H) addr = wa + 32'(2 * $urandom_range(0, 1));
            d_we = we; d_size = size; d_se = se; d_addr = addr; d_wdata = wdata;
            d_others = 0; d_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(posedge clk_i); #1;
                if (d_ack) begin got = 1'b1; break; end
            end
            if (!got) begin
                chk("rnd_d_ack_seen", 32'(got), 32'd1);
            end else begin
                exp_err = addr_err(wa);
                if (if_req) i_others++;
                chk("rnd_d_wait_bound", 32'(d_others <= 1), 32'd1);
                chk("rnd_d_err", 32'(d_err), 32'(exp_err));
                chk("rnd_d_adr", lb_adr, wa);
                chk("rnd_d_we", 32'(lb_we), 32'(we));
                chk("rnd_d_sel", 32'(lb_sel), 32'(ref_sel(size, addr)));
                if (we) chk("rnd_d_wdat", lb_dat, ref_wdat(size, wdata));
                if (!we && !exp_err) chk("rnd_d_rdata", d_rdata, ref_load(size, se, addr, mem_word(wa)));
            end
            d_req = 1'b0;
        end
    endtask

    task automatic rand_fetch(input int n);
        logic [31:0] wa; logic got;
        for (int t = 0; t < n; t++) begin
            @(negedge clk_i);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            wa = ($urandom & 32'h0000_3FFC) | 32'h0040_0000;
            if_addr = wa; i_others = 0; if_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(posedge clk_i); #1;
                if (if_ack) begin got = 1'b1; break; end
            end
            if (!got) begin
                chk("rnd_if_ack_seen", 32'(got), 32'd1);
            end else begin
                if (d_req) d_others++;
                chk("rnd_if_wait_bound", 32'(i_others <= 1), 32'd1);
                chk("rnd_if_err", 32'(if_err), 32'(addr_err(wa)));
                chk("rnd_if_adr", lb_adr, wa);
                chk("rnd_if_sel", 32'(lb_sel), 32'hF);
                chk("rnd_if_we", 32'(lb_we), 32'd0);
                if (!addr_err(wa)) chk("rnd_if_rdata", if_rdata, mem_word(wa));
            end
            if_req = 1'b0;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        se;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        serr;
        logic        misal;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] rdata;
    } dvec_t;

    dvec_t tv[12];

    initial begin
        logic        e, sc, bwe;
        logic [31:0] rdv, bdat, model_rd;
        logic        model_ok;
        logic [3:0]  bsel;
        int          lat, dcnt, icnt, acks, hold, cyc_n;
        logic [31:0] exp_q[$];
        int          rd_left, ri_left;
        logic        last_d;

        tv[0]  = '{1'b0, SZ_B, 1'b1, 32'h203, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tv[1]  = '{1'b0, SZ_B, 1'b0, 32'h203, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        tv[2]  = '{1'b1, SZ_H, 1'b0, 32'h202, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
        tv[3]  = '{1'b0, SZ_H, 1'b0, 32'h201, 32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tv[4]  = '{1'b0, SZ_W, 1'b1, 32'h204, 32'h0,        32'h87654321, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h87654321};
        tv[5]  = '{1'b0, SZ_B, 1'b0, 32'h201, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 4'b0010, 32'h0,        32'h0000007F};
        tv[6]  = '{1'b0, SZ_H, 1'b1, 32'h200, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 4'b0011, 32'h0,        32'h00007F01};
        tv[7]  = '{1'b0, SZ_H, 1'b1, 32'h202, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF80FF};
        tv[8]  = '{1'b1, SZ_B, 1'b0, 32'h201, 32'h000000A5, 32'h0,        1'b0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        tv[9]  = '{1'b1, SZ_W, 1'b0, 32'h20A, 32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tv[10] = '{1'b1, SZ_W, 1'b0, 32'h208, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
        tv[11] = '{1'b0, SZ_W, 1'b0, 32'h20C, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'h0,        32'h0};

        rst_i = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = SZ_W; d_se = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;

        // reset state
        chk("rst_cyc",  32'(wb_cyc_o), 32'd0);
        chk("rst_stb",  32'(wb_stb_o), 32'd0);
        chk("rst_we",   32'(wb_we_o),  32'd0);
        chk("rst_adr",  wb_adr_o, 32'd0);
        chk("rst_sel",  32'(wb_sel_o), 32'd0);
        chk("rst_dat",  wb_dat_o, 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_if_err", 32'(if_err), 32'd0);
        chk("rst_d_ack",  32'(d_ack),  32'd0);
        chk("rst_d_err",  32'(d_err),  32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata",  d_rdata,  32'd0);

        // zero-wait fetch and misaligned fetch
        slave_rdata = 32'h2402000A;
        do_fetch(32'h100, e, rdv, lat, sc, bsel, bwe);
        chk("fetch_lat",   32'(lat), 32'd2);
        chk("fetch_rdata", rdv, 32'h2402000A);
        chk("fetch_err",   32'(e), 32'd0);
        chk("fetch_sel",   32'(bsel), 32'hF);
        chk("fetch_we",    32'(bwe), 32'd0);
        do_fetch(32'h102, e, rdv, lat, sc, bsel, bwe);
        chk("fetch_mis_lat", 32'(lat), 32'd1);
        chk("fetch_mis_err", 32'(e), 32'd1);
        chk("fetch_mis_nobus", 32'(sc), 32'd0);

        // directed data vectors
        model_rd = 32'h0; model_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            slave_rdata = tv[i].rd;
            err_force   = tv[i].serr;
            do_data(tv[i].we, tv[i].size, tv[i].se, tv[i].addr, tv[i].wdata, e, rdv, lat, sc, bsel, bdat, bwe);
            chk($sformatf("v%0d_lat", i), 32'(lat), tv[i].misal ? 32'd1 : 32'd2);
            chk($sformatf("v%0d_bus", i), 32'(sc), tv[i].misal ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_err", i), 32'(e), 32'(tv[i].misal | tv[i].serr));
            if (!tv[i].misal) begin
                chk($sformatf("v%0d_sel", i), 32'(bsel), 32'(tv[i].sel));
                chk($sformatf("v%0d_we", i),  32'(bwe),  32'(tv[i].we));
                if (tv[i].we) chk($sformatf("v%0d_wdat", i), bdat, tv[i].dat);
            end
            if (tv[i].misal || tv[i].serr) begin
                model_ok = 1'b0;
            end else if (!tv[i].we) begin
                chk($sformatf("v%0d_rdata", i), rdv, tv[i].rdata);
                model_rd = tv[i].rdata; model_ok = 1'b1;
            end else if (model_ok) begin
                chk($sformatf("v%0d_rdata_kept", i), rdv, model_rd);
            end
        end
        err_force = 1'b0;

        // tie out of reset: both ports held for three transactions each
        do_reset();
        grant_q.delete();
        @(negedge clk_i);
        d_we = 1'b0; d_size = SZ_W; d_se = 1'b0; d_addr = 32'h2000; if_addr = 32'h1000;
        d_req = 1'b1; if_req = 1'b1;
        dcnt = 0; icnt = 0;
        fork
            for (int c = 0; c < 60; c++) begin
                @(posedge clk_i); #1;
                if (d_ack) begin
                    dcnt++;
                    if (dcnt == 3) begin d_req = 1'b0; break; end
                end
            end
            for (int c = 0; c < 60; c++) begin
                @(posedge clk_i); #1;
                if (if_ack) begin
                    icnt++;
                    if (icnt == 3) begin if_req = 1'b0; break; end
                end
            end
        join
        d_req = 1'b0; if_req = 1'b0;
        repeat (3) @(posedge clk_i);
        chk("tie_d_acks",  32'(dcnt), 32'd3);
        chk("tie_if_acks", 32'(icnt), 32'd3);
        rd_left = 3; ri_left = 3; last_d = 1'b0;
        while (rd_left > 0 || ri_left > 0) begin
            if (rd_left > 0 && (ri_left == 0 || !last_d)) begin
                exp_q.push_back(32'h2000); rd_left--; last_d = 1'b1;
            end else begin
                exp_q.push_back(32'h1000); ri_left--; last_d = 1'b0;
            end
        end
        chk("tie_grants", 32'(grant_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            chk($sformatf("tie_order%0d", i), grant_q[i], exp_q[i]);

        // randomized concurrent traffic
        rand_mode = 1'b1;
        fork
            rand_data(30);
            rand_fetch(30);
        join
        rand_mode = 1'b0;
        repeat (3) @(posedge clk_i);

`ifdef JPU_ARB_TIMEOUT_EN
        // silent slave: watchdog closes the cycle
        slave_silent = 1'b1;
        @(negedge clk_i);
        d_we = 1'b0; d_size = SZ_W; d_addr = 32'h300; d_req = 1'b1;
        cyc_n = 0; acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            if (wb_cyc_o) cyc_n++;
            if (d_ack) begin acks = 1; chk("tmo_err", 32'(d_err), 32'd1); break; end
        end
        d_req = 1'b0;
        chk("tmo_ack", 32'(acks), 32'd1);
        chk("tmo_cycles", 32'(cyc_n), 32'd4);
        repeat (2) @(posedge clk_i);
        hold = 2;
`else
        hold = 12;
`endif

        // reset during a bus cycle to a silent slave
        slave_silent = 1'b1;
        @(negedge clk_i);
        d_we = 1'b0; d_size = SZ_W; d_addr = 32'h400; d_req = 1'b1;
        acks = 0;
        repeat (hold) begin
            @(posedge clk_i); #1;
            if (d_ack) acks++;
        end
        chk("hang_cyc", 32'(wb_cyc_o), 32'd1);
        chk("hang_no_ack", 32'(acks), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1; d_req = 1'b0;
        #1;
        chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("arst_stb", 32'(wb_stb_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (d_ack) acks++;
        end
        chk("arst_no_ack", 32'(acks), 32'd0);
        slave_silent = 1'b0;
        slave_rdata  = 32'h0BADF00D;
        do_data(1'b0, SZ_W, 1'b0, 32'h404, 32'h0, e, rdv, lat, sc, bsel, bdat, bwe);
        chk("post_rst_lat",   32'(lat), 32'd2);
        chk("post_rst_err",   32'(e), 32'd0);
        chk("post_rst_rdata", rdv, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
